// File: rtl/keycode_encoder.sv
// -----------------------------------------------------------------------------
// keycode_encoder
//
// Turns four raw arrow-key buttons into keyboard-style reports. Each button is
// synchronized and debounced; the debounced set drives an ordered slot list
// (press order, no gaps), and every change to that list is offered once to a
// consumer over a valid/ready handshake.
//
// Handshake: keycode_valid rises with a new report on keycode. keycode and
// keycode_valid stay frozen until a cycle where keycode_ready is also 1; that
// cycle transfers the report and valid drops on the following edge. Slot
// changes while a report is waiting are merged into a single follow-up report
// carrying the newest slot list.
//
// Optional feature: define KEYCODE_REPEAT_EN to re-issue the current slot list
// every REPEAT_PERIOD idle cycles while any key is held. Without the macro,
// reports are issued only when the slot list changes.
//
// Ports
//   pxl_clk        in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   btn_left       in   raw button level, 1 = pressed
//   btn_down       in   raw button level, 1 = pressed
//   btn_up         in   raw button level, 1 = pressed
//   btn_right      in   raw button level, 1 = pressed
//   keycode        out  [31:0] report, slot0 = [7:0] ... slot3 = [31:24], 0 = empty
//   keycode_valid  out  report offered
//   keycode_ready  in   consumer accepts when valid & ready
//   held           out  [3:0] debounced state {right, up, down, left}
// -----------------------------------------------------------------------------
module keycode_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_PERIOD   = 1000000
) (
   input  logic        pxl_clk,
   input  logic        rst_n,
   input  logic        btn_left,
   input  logic        btn_down,
   input  logic        btn_up,
   input  logic        btn_right,
   output logic [31:0] keycode,
   output logic        keycode_valid,
   input  logic        keycode_ready,
   output logic [3:0]  held
);

   localparam logic [0:0]  ST_IDLE  = 1'b0;
   localparam logic [0:0]  ST_SEND  = 1'b1;
   localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   // Bit order everywhere: 0 = left, 1 = down, 2 = up, 3 = right.
   function automatic logic [7:0] key_code(input int unsigned idx);
      case (idx)
         0:       key_code = 8'h50;
         1:       key_code = 8'h51;
         2:       key_code = 8'h52;
         default: key_code = 8'h4F;
      endcase
   endfunction

   logic [3:0]       btn_raw;
   logic [3:0]       meta_q, sync_q;
   logic [15:0]      cnt_q [4];
   logic [15:0]      cnt_d [4];
   logic [3:0]       held_q, held_d;
   logic [3:0]       press, release_evt;
   logic             slot_change;
   logic [3:0][7:0]  slots_q, slots_d;
   logic             dirty_q, dirty_d;
   logic [0:0]       state_q, state_d;
   logic [31:0]      keycode_q, keycode_d;
   logic             valid_q, valid_d;
   logic             load_report;
   logic             repeat_fire;

   assign btn_raw = {btn_right, btn_up, btn_down, btn_left};

   // Debounce: a button's held bit flips only after the synchronized level
   // has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i]  = '0;
         held_d[i] = held_q[i];
         if (sync_q[i] != held_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               held_d[i] = ~held_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end
      end
   end

   // Events are taken from the held transition itself so the slot list is
   // updated on the same edge as held.
   assign press       = held_d & ~held_q;
   assign release_evt = held_q & ~held_d;
   assign slot_change = |(press | release_evt);

   // Slot list update: compact away released keys (keeping order), then
   // append new presses in fixed priority left, down, up, right.
   always_comb begin
      logic [2:0] wr_idx;
      logic       keep;
      slots_d = '0;
      wr_idx  = 3'd0;
      for (int j = 0; j < 4; j++) begin
         keep = (slots_q[j] != 8'h00);
         for (int i = 0; i < 4; i++) begin
            if (release_evt[i] && (slots_q[j] == key_code(i))) begin
               keep = 1'b0;
            end
         end
         if (keep && !wr_idx[2]) begin
            slots_d[wr_idx[1:0]] = slots_q[j];
            wr_idx = wr_idx + 3'd1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (press[i] && !wr_idx[2]) begin
            slots_d[wr_idx[1:0]] = key_code(i);
            wr_idx = wr_idx + 3'd1;
         end
      end
   end

   // Report FSM.
   always_comb begin
      state_d     = state_q;
      keycode_d   = keycode_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      load_report = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dirty_q || repeat_fire) begin
               keycode_d   = slots_q;
               valid_d     = 1'b1;
               load_report = 1'b1;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (keycode_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      if (load_report) begin
         dirty_d = 1'b0;
      end
      // A change on the load cycle itself must not be lost, so it wins.
      if (slot_change) begin
         dirty_d = 1'b1;
      end
   end

`ifdef KEYCODE_REPEAT_EN
   localparam logic [31:0] RPT_LAST = 32'(REPEAT_PERIOD - 1);

   logic [31:0] rpt_q, rpt_d;
   logic        rpt_counting;

   assign rpt_counting = (state_q == ST_IDLE) && !dirty_q && (|held_q);
   assign repeat_fire  = rpt_counting && (rpt_q == RPT_LAST);

   always_comb begin
      rpt_d = rpt_q;
      if (load_report || slot_change || !(|held_q)) begin
         rpt_d = '0;
      end else if (rpt_counting) begin
         rpt_d = rpt_q + 32'd1;
      end
   end

   always_ff @(posedge pxl_clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_q <= '0;
      end else begin
         rpt_q <= rpt_d;
      end
   end
`else
   logic unused_repeat_period;
   assign unused_repeat_period = |REPEAT_PERIOD;
   assign repeat_fire          = 1'b0;
`endif

   always_ff @(posedge pxl_clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q    <= '0;
         sync_q    <= '0;
         held_q    <= '0;
         slots_q   <= '0;
         dirty_q   <= 1'b0;
         state_q   <= ST_IDLE;
         keycode_q <= '0;
         valid_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         meta_q    <= btn_raw;
         sync_q    <= meta_q;
         held_q    <= held_d;
         slots_q   <= slots_d;
         dirty_q   <= dirty_d;
         state_q   <= state_d;
         keycode_q <= keycode_d;
         valid_q   <= valid_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign keycode       = keycode_q;
   assign keycode_valid = valid_q;
   assign held          = held_q;

endmodule

// File: tb/tb_keycode_encoder.sv
// -----------------------------------------------------------------------------
// tb_keycode_encoder
//
// Directed bench for keycode_encoder with DEBOUNCE_CYCLES = 4. Stimulus pushes
// each expected report into exp_q when it changes the buttons; an independent
// monitor pops and compares on every accepted report and also checks that a
// stalled report stays frozen. Default build (repeat feature off).
// -----------------------------------------------------------------------------
module tb_keycode_encoder;

   localparam int DEB = 4;

   logic        pxl_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_down = 1'b0;
   logic        btn_up = 1'b0;
   logic        btn_right = 1'b0;
   logic        keycode_ready = 1'b1;
   logic [31:0] keycode;
   logic        keycode_valid;
   logic [3:0]  held;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];
   logic        stalled = 1'b0;
   logic [31:0] stall_val = '0;
   logic [31:0] exp_val;

   keycode_encoder #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_PERIOD  (10)
   ) dut (
      .pxl_clk      (pxl_clk),
      .rst_n        (rst_n),
      .btn_left     (btn_left),
      .btn_down     (btn_down),
      .btn_up       (btn_up),
      .btn_right    (btn_right),
      .keycode      (keycode),
      .keycode_valid(keycode_valid),
      .keycode_ready(keycode_ready),
      .held         (held)
   );

   // ---------------- clock ----------------
   always #5 pxl_clk = ~pxl_clk;

   // ---------------- helpers ----------------
   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge pxl_clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int k;
      k = 0;
      while (!keycode_valid && k < budget) begin
         tick(1);
         k++;
      end
      tests++;
      if (!keycode_valid) begin
         fails++;
         $display("[TB] FAIL %s: valid not seen within %0d cycles", name, budget);
      end
   endtask

   task automatic check_drained(input string name);
      check32(name, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge pxl_clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else if (keycode_valid) begin
         if (stalled) begin
            check32("stall_stable", keycode, stall_val);
         end
         if (keycode_ready) begin
            stalled = 1'b0;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_report: got %h expected none at %0t", keycode, $time);
            end else begin
               exp_val = exp_q.pop_front();
               check32("report", keycode, exp_val);
            end
         end else if (!stalled) begin
            stalled   = 1'b1;
            stall_val = keycode;
         end
      end else if (stalled) begin
         tests++;
         fails++;
         stalled = 1'b0;
         $display("[TB] FAIL valid_dropped: got 0 expected 1 while stalled at %0t", $time);
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      tick(3);
      check32("rst_keycode", keycode, 32'h0);
      check32("rst_valid", 32'(keycode_valid), 32'h0);
      check32("rst_held", 32'(held), 32'h0);
      rst_n = 1'b1;
      tick(2);

      // Clean left press: held after 2+DEB cycles, valid one cycle later.
      btn_left = 1'b1;
      exp_q.push_back(32'h0000_0050);
      tick(5);
      check32("t1_held_early", 32'(held), 32'h0);
      tick(1);
      check32("t1_held", 32'(held), 32'h1);
      check32("t1_valid_pre", 32'(keycode_valid), 32'h0);
      tick(1);
      check32("t1_valid", 32'(keycode_valid), 32'h1);
      check32("t1_keycode", keycode, 32'h0000_0050);
      tick(1);
      check32("t1_valid_pulse", 32'(keycode_valid), 32'h0);
      tick(8);
      btn_left = 1'b0;
      exp_q.push_back(32'h0000_0000);
      tick(16);
      check_drained("t1_drain");

      // Press order and gap-free removal.
      btn_left = 1'b1; exp_q.push_back(32'h0000_0050); tick(12);
      btn_up   = 1'b1; exp_q.push_back(32'h0000_5250); tick(12);
      btn_left = 1'b0; exp_q.push_back(32'h0000_0052); tick(12);
      check32("t2_held", 32'(held), 32'h4);
      btn_up   = 1'b0; exp_q.push_back(32'h0000_0000); tick(12);
      check_drained("t2_drain");

      // Same-cycle presses follow left, down, up, right priority.
      btn_down = 1'b1; btn_right = 1'b1;
      exp_q.push_back(32'h0000_4F51);
      tick(12);
      check32("t3_held", 32'(held), 32'hA);
      btn_down = 1'b0; btn_right = 1'b0;
      exp_q.push_back(32'h0000_0000);
      tick(12);
      check_drained("t3_drain");

      // Consumer stall: changes during SEND coalesce into one report.
      keycode_ready = 1'b0;
      btn_left = 1'b1;
      exp_q.push_back(32'h0000_0050);
      wait_valid("t4_first", 20);
      check32("t4_first_kc", keycode, 32'h0000_0050);
      btn_up = 1'b1; tick(8);
      btn_up = 1'b0; tick(12);
      check32("t4_stall_kc", keycode, 32'h0000_0050);
      check32("t4_stall_valid", 32'(keycode_valid), 32'h1);
      exp_q.push_back(32'h0000_0050);
      keycode_ready = 1'b1;
      tick(12);
      btn_left = 1'b0;
      exp_q.push_back(32'h0000_0000);
      tick(12);
      check_drained("t4_drain");

      // Bounce shorter than the debounce window is ignored.
      for (int p = 0; p < 3; p++) begin
         btn_up = (p != 1);
         for (int c = 0; c < 3; c++) begin
            tick(1);
            check32("t5_bounce_held", 32'(held), 32'h0);
            check32("t5_bounce_valid", 32'(keycode_valid), 32'h0);
         end
      end
      btn_up = 1'b0;
      tick(10);
      check32("t5_held_after", 32'(held), 32'h0);

      // Reset during SEND drops valid immediately; no report afterwards.
      keycode_ready = 1'b0;
      btn_right = 1'b1;
      exp_q.push_back(32'h0000_004F);
      wait_valid("t6_send", 20);
      tick(2);
      #2;
      rst_n = 1'b0;
      #1;
      check32("t6_rst_valid", 32'(keycode_valid), 32'h0);
      check32("t6_rst_keycode", keycode, 32'h0);
      check32("t6_rst_held", 32'(held), 32'h0);
      exp_q.delete();
      btn_right = 1'b0;
      tick(3);
      rst_n = 1'b1;
      keycode_ready = 1'b1;
      tick(20);
      check32("t6_no_report", 32'(keycode_valid), 32'h0);

      // Holding a key without the repeat feature gives exactly one report.
      btn_right = 1'b1;
      exp_q.push_back(32'h0000_004F);
      tick(40);
      check32("t7_held", 32'(held), 32'h8);
      btn_right = 1'b0;
      exp_q.push_back(32'h0000_0000);
      tick(16);
      check_drained("t7_drain");

      tick(5);
      check_drained("final_drain");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
